// File: rtl/dds_pkg.sv
// Shared constants for the DDS generator: shape codes, phase scaling, sample width
// and DAC saturation limits, plus the output saturation helper.
package dds_pkg;

  localparam int OUT_W     = 12;
  localparam int INC_SCALE = 4295;

  localparam logic [1:0] SHAPE_SINE   = 2'd0;
  localparam logic [1:0] SHAPE_SQUARE = 2'd1;
  localparam logic [1:0] SHAPE_TRI    = 2'd2;
  localparam logic [1:0] SHAPE_SAW    = 2'd3;

  localparam logic [11:0] SAT_MIN = 12'd0;
  localparam logic [11:0] SAT_MAX = 12'd4095;

  function automatic logic [11:0] sat_code(input logic signed [24:0] v);
    logic [11:0] r;
    if (v < 25'sd0) begin
      r = SAT_MIN;
    end else if (v > $signed({13'd0, SAT_MAX})) begin
      r = SAT_MAX;
    end else begin
      r = v[11:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_gen_sine_lut.sv
// Registered quarter-wave sine table: 10-bit quarter-phase address in, 11-bit magnitude out.
// Contents follow the cubic (3x - x^3)/2 fit of sin(pi*x/2), scaled to 2047.
module sine_lut
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  addr,
  output logic [10:0] mag
);

  function automatic logic [10:0] quarter_sine(input logic [9:0] a);
    logic [63:0] x;
    logic [63:0] num;
    x   = {54'd0, a};
    num = (64'd3 * x * 64'd1048576) - (x * x * x);
    return 11'((num * 64'd2047) >> 31);
  endfunction

  logic [10:0] mag_d, mag_q;

  always_comb begin
    mag_d = quarter_sine(addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= 11'd0;
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/dds_gen.sv
// Direct digital synthesis generator with shadowed parameter sets and a 3-stage output pipeline.
// Define DDS_PHASE_SYNC_EN to defer parameter updates to the phase-wrap tick.
module dds_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = dds_pkg::OUT_W,
  parameter int SAMPLE_DIV = 100,
  parameter int INC_SCALE  = dds_pkg::INC_SCALE
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             data_ready,
  input  logic [7:0]       var_1,
  input  logic [15:0]      var_2,
  input  logic [15:0]      var_3,
  input  logic [15:0]      var_4,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             param_update,
  output logic             shape_err
);

  localparam int                 CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [PHASE_W-1:0] INC_K    = PHASE_W'(INC_SCALE);

  logic               dr_d, dr_q, tick_d, tick_q, pend_d, pend_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [PHASE_W-1:0] phase_d, phase_q, sh_inc_d, sh_inc_q, act_inc_d, act_inc_q;
  logic [1:0]         sh_shape_d, sh_shape_q, act_shape_d, act_shape_q;
  logic [11:0]        sh_amp_d, sh_amp_q, act_amp_d, act_amp_q, amp1_d, amp1_q;
  logic [15:0]        sh_off_d, sh_off_q, act_off_d, act_off_q;
  logic [15:0]        off1_d, off1_q, off2_d, off2_q;
  logic               pu_d, pu_q, serr_d, serr_q, v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic signed [11:0] wave_d, wave_q;
  logic signed [24:0] prod_d, prod_q, sum_out_s;
  logic [OUT_W-1:0]   smp_d, smp_q;

  logic               load_s, shape_ok_s, apply_s, wrap_ok_s;
  logic [PHASE_W-1:0] sum_s;
  logic [11:0]        p_s;
  logic [10:0]        tri_u_s, lut_mag_s;
  logic [9:0]         lut_addr_s;
  logic signed [11:0] wave_s;
`ifdef DDS_PHASE_SYNC_EN
  logic               carry_s;
`endif

  // The table sees phase_q every cycle; phase only moves on ticks, so its output is current by the next tick.
  sine_lut u_sine_lut (
    .clk  (clk_100MHz),
    .rst  (rst),
    .addr (lut_addr_s),
    .mag  (lut_mag_s)
  );

  always_comb begin
    load_s     = data_ready & ~dr_q;
    shape_ok_s = (var_1[7:2] == 6'd0);
`ifdef DDS_PHASE_SYNC_EN
    {carry_s, sum_s} = {1'b0, phase_q} + {1'b0, act_inc_q};
    wrap_ok_s        = carry_s | (act_inc_q == '0);
`else
    sum_s     = phase_q + act_inc_q;
    wrap_ok_s = 1'b1;
`endif
    apply_s = tick_q & pend_q & wrap_ok_s;

    dr_d    = data_ready;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d  = (cnt_q == CNT_LAST);
    phase_d = tick_q ? sum_s : phase_q;

    act_shape_d = apply_s ? sh_shape_q : act_shape_q;
    act_inc_d   = apply_s ? sh_inc_q   : act_inc_q;
    act_amp_d   = apply_s ? sh_amp_q   : act_amp_q;
    act_off_d   = apply_s ? sh_off_q   : act_off_q;
    pu_d        = apply_s;

    // A capture in the apply cycle wins: the applied set came from the old shadow.
    if (load_s & shape_ok_s) begin
      sh_shape_d = var_1[1:0];
      sh_inc_d   = PHASE_W'(var_2) * INC_K;
      sh_amp_d   = (var_4 > 16'd4095) ? 12'd4095 : var_4[11:0];
      sh_off_d   = var_3;
      pend_d     = 1'b1;
      serr_d     = 1'b0;
    end else begin
      sh_shape_d = sh_shape_q;
      sh_inc_d   = sh_inc_q;
      sh_amp_d   = sh_amp_q;
      sh_off_d   = sh_off_q;
      pend_d     = pend_q & ~apply_s;
      serr_d     = load_s;
    end

    p_s        = phase_q[PHASE_W-1 -: 12];
    tri_u_s    = p_s[11] ? ~p_s[10:0] : p_s[10:0];
    lut_addr_s = p_s[10] ? ~p_s[9:0] : p_s[9:0];
    case (act_shape_q)
      SHAPE_SAW:    wave_s = {~p_s[11], p_s[10:0]};
      SHAPE_SQUARE: wave_s = p_s[11] ? 12'h800 : 12'h7FF;
      SHAPE_TRI:    wave_s = {~tri_u_s[10], tri_u_s[9:0], 1'b0};
      default:      wave_s = p_s[11] ? -{1'b0, lut_mag_s} : {1'b0, lut_mag_s};
    endcase

    wave_d    = wave_s;
    amp1_d    = act_amp_q;
    off1_d    = act_off_q;
    v1_d      = tick_q;
    prod_d    = wave_q * $signed({1'b0, amp1_q});
    off2_d    = off1_q;
    v2_d      = v1_q;
    sum_out_s = $signed({9'd0, off2_q}) + (prod_q >>> 5'd12);
    smp_d     = v2_q ? OUT_W'(sat_code(sum_out_s)) : smp_q;
    v3_d      = v2_q;
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      dr_q        <= 1'b0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      phase_q     <= '0;
      pend_q      <= 1'b0;
      sh_shape_q  <= SHAPE_SINE;
      sh_inc_q    <= '0;
      sh_amp_q    <= 12'd0;
      sh_off_q    <= 16'd0;
      act_shape_q <= SHAPE_SINE;
      act_inc_q   <= '0;
      act_amp_q   <= 12'd0;
      act_off_q   <= 16'd0;
      pu_q        <= 1'b0;
      serr_q      <= 1'b0;
      wave_q      <= 12'sd0;
      amp1_q      <= 12'd0;
      off1_q      <= 16'd0;
      v1_q        <= 1'b0;
      prod_q      <= 25'sd0;
      off2_q      <= 16'd0;
      v2_q        <= 1'b0;
      smp_q       <= '0;
      v3_q        <= 1'b0;
    end else begin
      dr_q        <= dr_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      sh_shape_q  <= sh_shape_d;
      sh_inc_q    <= sh_inc_d;
      sh_amp_q    <= sh_amp_d;
      sh_off_q    <= sh_off_d;
      act_shape_q <= act_shape_d;
      act_inc_q   <= act_inc_d;
      act_amp_q   <= act_amp_d;
      act_off_q   <= act_off_d;
      pu_q        <= pu_d;
      serr_q      <= serr_d;
      wave_q      <= wave_d;
      amp1_q      <= amp1_d;
      off1_q      <= off1_d;
      v1_q        <= v1_d;
      prod_q      <= prod_d;
      off2_q      <= off2_d;
      v2_q        <= v2_d;
      smp_q       <= smp_d;
      v3_q        <= v3_d;
    end
  end

  assign sample       = smp_q;
  assign sample_valid = v3_q;
  assign param_update = pu_q;
  assign shape_err    = serr_q;

endmodule

// File: tb/tb_dds_gen.sv
// Self-checking bench for dds_gen: tick-level reference model feeding a sample scoreboard,
// a table of parameter loads, and hand-written reset / same-cycle sequences.
module tb_dds_gen;

  logic        clk_100MHz = 1'b0;
  logic        rst        = 1'b1;
  logic        data_ready = 1'b0;
  logic [7:0]  var_1      = 8'd0;
  logic [15:0] var_2      = 16'd0;
  logic [15:0] var_3      = 16'd0;
  logic [15:0] var_4      = 16'd0;
  logic [11:0] sample;
  logic        sample_valid, param_update, shape_err;

  dds_gen dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .data_ready   (data_ready),
    .var_1        (var_1),
    .var_2        (var_2),
    .var_3        (var_3),
    .var_4        (var_4),
    .sample       (sample),
    .sample_valid (sample_valid),
    .param_update (param_update),
    .shape_err    (shape_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct { int code; int due; } exp_t;
  typedef struct { int shape; int freq; int off; int amp; int exp_err; int exp_upd; } vec_t;

  exp_t        sb_q[$];
  int          errors = 0, checks = 0;
  int          edge_n = 0, pu_cnt = 0, se_cnt = 0;
  bit          m_dr = 1'b0, m_pend = 1'b0;
  int          m_shape = 0, m_amp = 0, m_off = 0, sh_shape = 0, sh_amp = 0, sh_off = 0;
  logic [31:0] m_phase = 32'd0, m_inc = 32'd0, sh_inc = 32'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Sine is only ever active with zero amplitude in this bench, so its wave value never matters.
  function automatic int exp_sample(input int shape, input logic [31:0] ph, input int amp, input int off);
    int p, u, w, v;
    p = int'(ph[31:20]);
    case (shape)
      3: w = p - 2048;
      1: w = (p < 2048) ? 2047 : -2048;
      2: begin u = (p >= 2048) ? 4095 - p : p; w = 2 * u - 2048; end
      default: w = 0;
    endcase
    v = off + ((w * amp) >>> 12);
    if (v < 0) v = 0;
    else if (v > 4095) v = 4095;
    return v;
  endfunction

  task automatic model_edge();
    logic [32:0] s;
    bit ok;
    if (rst) begin
      edge_n = 0; m_dr = 1'b0; m_pend = 1'b0;
      m_shape = 0; m_amp = 0; m_off = 0; m_phase = 32'd0; m_inc = 32'd0;
      sb_q.delete();
    end else begin
      edge_n++;
      if (edge_n > 1 && edge_n % 100 == 1) begin
        sb_q.push_back('{exp_sample(m_shape, m_phase, m_amp, m_off), edge_n + 2});
        s = {1'b0, m_phase} + {1'b0, m_inc};
`ifdef DDS_PHASE_SYNC_EN
        ok = s[32] || (m_inc == 32'd0);
`else
        ok = 1'b1;
`endif
        if (m_pend && ok) begin
          m_shape = sh_shape; m_inc = sh_inc; m_amp = sh_amp; m_off = sh_off; m_pend = 1'b0;
        end
        m_phase = s[31:0];
      end
      if (data_ready && !m_dr && var_1 < 8'd4) begin
        sh_shape = int'(var_1);
        sh_inc   = 32'(var_2) * 32'd4295;
        sh_amp   = (var_4 > 16'd4095) ? 4095 : int'(var_4);
        sh_off   = int'(var_3);
        m_pend   = 1'b1;
      end
      m_dr = data_ready;
    end
  endtask

  task automatic observe();
    exp_t e;
    if (sample_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sample_value", int'(sample), e.code);
        check("sample_time", edge_n, e.due);
      end
    end else if (sb_q.size() != 0 && sb_q[0].due <= edge_n) begin
      e = sb_q.pop_front();
      check("valid_at_due", int'(sample_valid), 1);
    end
    if (param_update) pu_cnt++;
    if (shape_err) se_cnt++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_100MHz);
      model_edge();
      #1;
      observe();
    end
  endtask

  task automatic load(input int shape, input int freq, input int off, input int amp);
    var_1 = 8'(shape); var_2 = 16'(freq); var_3 = 16'(off); var_4 = 16'(amp);
    data_ready = 1'b1;
    step(3);
    data_ready = 1'b0;
    step(1);
  endtask

  task automatic wait_valid(output int val);
    int i;
    i = 0;
    step(1);
    while (!sample_valid && i < 150) begin step(1); i++; end
    check("valid_seen", int'(sample_valid), 1);
    val = int'(sample);
  endtask

  task automatic wait_mod(input int m);
    int i;
    i = 0;
    while (edge_n % 100 != m && i < 100) begin step(1); i++; end
  endtask

  task automatic check_reset_outputs();
    check("rst_sample", int'(sample), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_param_update", int'(param_update), 0);
    check("rst_shape_err", int'(shape_err), 0);
  endtask

  task automatic wait_first_valid();
    int i;
    i = 0;
    while (!sample_valid && i < 300) begin step(1); i++; end
    check("first_valid_latency", edge_n, 103);
  endtask

  initial begin
    vec_t vecs[5];
    int   smp, s1, s2, hi, lo, other, i;
    vecs[0] = '{7,   2000, 0,    0,    1, 0};
    vecs[1] = '{2,   2000, 1000, 5000, 0, 1};
    vecs[2] = '{255, 100,  0,    0,    1, 0};
    vecs[3] = '{3,   65535, 0,   4095, 0, 1};
    vecs[4] = '{1,   500,  4000, 4095, 0, 1};

    // Reset state and idle output cadence.
    step(3);
    check_reset_outputs();
    rst = 1'b0;
    wait_first_valid();
    check("idle_sample", int'(sample), 0);
    step(250);

    // Sawtooth from phase 0: apply-tick sample is the old set, then 0, then 4.
    pu_cnt = 0;
    load(3, 1000, 2048, 4095);
    i = 0;
    while (pu_cnt == 0 && i < 250) begin step(1); i++; end
    check("saw_update_seen", pu_cnt, 1);
    wait_valid(smp);
    wait_valid(s1);
    wait_valid(s2);
    check("saw_first_sample", s1, 0);
    check("saw_second_sample", s2, 4);

    for (int v = 0; v < 5; v++) begin
      pu_cnt = 0; se_cnt = 0;
      load(vecs[v].shape, vecs[v].freq, vecs[v].off, vecs[v].amp);
      step(300);
      check($sformatf("vec%0d_shape_err", v), se_cnt, vecs[v].exp_err);
      check($sformatf("vec%0d_param_update", v), pu_cnt, vecs[v].exp_upd);
    end

    // Square with fast phase: both saturated-high and low levels must appear.
    load(1, 30000, 4000, 4095);
    wait_valid(smp);
    wait_valid(smp);
    hi = 0; lo = 0; other = 0;
    for (int k = 0; k < 40; k++) begin
      wait_valid(smp);
      if (smp == 4095) hi++;
      else if (smp == 1952) lo++;
      else other++;
    end
    check("square_high_seen", int'(hi > 0), 1);
    check("square_low_seen", int'(lo > 0), 1);
    check("square_other_levels", other, 0);

    // Rejected set while another is pending leaves the pending set intact.
    wait_mod(50);
    pu_cnt = 0; se_cnt = 0;
    load(3, 4000, 1000, 3000);
    load(9, 100, 0, 0);
    step(200);
    check("pending_kept_update", pu_cnt, 1);
    check("pending_kept_err", se_cnt, 1);

    // Capture coinciding with an apply tick stays pending for the following tick.
    wait_mod(50);
    pu_cnt = 0; se_cnt = 0;
    load(3, 1000, 2048, 4095);
    wait_mod(0);
    var_1 = 8'd2; var_2 = 16'd3000; var_3 = 16'd2048; var_4 = 16'd2000;
    data_ready = 1'b1;
    step(2);
    data_ready = 1'b0;
    step(250);
    check("same_cycle_updates", pu_cnt, 2);

    // Reset mid-waveform with a set pending: outputs clear and the set is dropped.
    wait_mod(50);
    load(3, 5000, 100, 3000);
    rst = 1'b1;
    step(3);
    check_reset_outputs();
    pu_cnt = 0;
    rst = 1'b0;
    wait_first_valid();
    check("post_reset_sample", int'(sample), 0);
    step(300);
    check("post_reset_no_update", pu_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
